// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: per-window spike count with a valid/ready result and
// overrun flag, plus an inter-spike-interval measurement between consecutive events.
module spike_rate_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spike_in,
    input  logic       en,
    input  logic [7:0] win_len,
    output logic [7:0] rate_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       overrun,
    output logic [7:0] isi_out,
    output logic       isi_upd
);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t     state_q, state_d;
    logic       spike_prev_q;
    logic [7:0] spk_cnt_q, spk_cnt_d;
    logic [7:0] win_cnt_q, win_cnt_d;
    logic [7:0] isi_cnt_q, isi_cnt_d;
    logic       isi_armed_q, isi_armed_d;
    logic [7:0] rate_q, rate_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] isi_out_q, isi_out_d;
    logic       isi_upd_q, isi_upd_d;

    logic       spike_evt;
    logic [7:0] win_last;
    logic       load;

    assign spike_evt = spike_in & ~spike_prev_q;
    // 8-bit wrap makes win_len=0 compare against 255, i.e. a 256-cycle window.
    assign win_last  = win_len - 8'd1;

    always_comb begin
        state_d     = state_q;
        spk_cnt_d   = spk_cnt_q;
        win_cnt_d   = win_cnt_q;
        isi_armed_d = isi_armed_q;
        rate_d      = rate_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        isi_out_d   = isi_out_q;
        isi_upd_d   = 1'b0;
        load        = 1'b0;
        isi_cnt_d   = (isi_cnt_q == 8'd255) ? 8'd255 : isi_cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                isi_armed_d = 1'b0;
                if (en) begin
                    state_d   = COUNT;
                    win_cnt_d = 8'd0;
                    spk_cnt_d = 8'd0;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d     = IDLE;
                    isi_armed_d = 1'b0;
                end else begin
                    if (win_cnt_q == win_last) begin
                        load      = 1'b1;
                        rate_d    = spk_cnt_q + {7'd0, spike_evt};
                        win_cnt_d = 8'd0;
                        spk_cnt_d = 8'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 8'd1;
                        spk_cnt_d = spk_cnt_q + {7'd0, spike_evt};
                    end
                    if (spike_evt) begin
                        isi_cnt_d   = 8'd1;
                        isi_armed_d = 1'b1;
                        if (isi_armed_q) begin
                            isi_out_d = isi_cnt_q;
                            isi_upd_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh result wins over a same-cycle handshake so valid stays high.
        if (load) begin
            valid_d = 1'b1;
            if (valid_q && !ready_in) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spike_prev_q <= 1'b0;
            spk_cnt_q    <= 8'd0;
            win_cnt_q    <= 8'd0;
            isi_cnt_q    <= 8'd0;
            isi_armed_q  <= 1'b0;
            rate_q       <= 8'd0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            isi_out_q    <= 8'd0;
            isi_upd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_prev_q <= spike_in;
            spk_cnt_q    <= spk_cnt_d;
            win_cnt_q    <= win_cnt_d;
            isi_cnt_q    <= isi_cnt_d;
            isi_armed_q  <= isi_armed_d;
            rate_q       <= rate_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            isi_out_q    <= isi_out_d;
            isi_upd_q    <= isi_upd_d;
        end
    end

    assign rate_out  = rate_q;
    assign valid_out = valid_q;
    assign overrun   = overrun_q;
    assign isi_out   = isi_out_q;
    assign isi_upd   = isi_upd_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic, every
// cycle compared against a window/timestamp model of the decoder.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spike_in;
    logic       en;
    logic [7:0] win_len;
    logic [7:0] rate_out;
    logic       valid_out;
    logic       ready_in;
    logic       overrun;
    logic [7:0] isi_out;
    logic       isi_upd;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit m_active, m_prev, m_armed, m_valid, m_over, m_upd;
    int m_pos, m_spikes, m_rate, m_isi, m_cycle, m_last_ev;

    spike_rate_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike_in  (spike_in),
        .en        (en),
        .win_len   (win_len),
        .rate_out  (rate_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .overrun   (overrun),
        .isi_out   (isi_out),
        .isi_upd   (isi_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_prev = 0; m_armed = 0; m_valid = 0; m_over = 0; m_upd = 0;
        m_pos = 0; m_spikes = 0; m_rate = 0; m_isi = 0; m_last_ev = 0;
    endtask

    // One clock of behaviour, from the inputs currently applied.
    task automatic model_step();
        bit ev, produce;
        int len, total;
        ev      = spike_in && !m_prev;
        len     = (win_len == 8'd0) ? 256 : int'(win_len);
        produce = 0;
        total   = 0;
        m_upd   = 0;
        if (!m_active) begin
            m_armed = 0;
            if (en) begin
                m_active = 1; m_pos = 0; m_spikes = 0;
            end
        end else if (!en) begin
            m_active = 0; m_armed = 0;
        end else begin
            total = m_spikes + int'(ev);
            if (m_pos == len - 1) begin
                produce = 1; m_pos = 0; m_spikes = 0;
            end else begin
                m_pos = (m_pos + 1) % 256; m_spikes = total;
            end
            if (ev) begin
                if (m_armed) begin
                    m_isi = (m_cycle - m_last_ev > 255) ? 255 : m_cycle - m_last_ev;
                    m_upd = 1;
                end
                m_armed   = 1;
                m_last_ev = m_cycle;
            end
        end
        if (produce) begin
            if (m_valid && !ready_in) m_over = 1;
            m_valid = 1;
            m_rate  = total;
        end else if (m_valid && ready_in) begin
            m_valid = 0;
        end
        m_prev = spike_in;
        m_cycle++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model.rate_out",  rate_out,  8'(m_rate));
        chk("model.valid_out", valid_out, 8'(m_valid));
        chk("model.overrun",   overrun,   8'(m_over));
        chk("model.isi_out",   isi_out,   8'(m_isi));
        chk("model.isi_upd",   isi_upd,   8'(m_upd));
    endtask

    task automatic cyc(input logic s);
        spike_in = s;
        step();
    endtask

    // Asynchronous reset asserted mid-cycle, held for two clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.rate_out",  rate_out,  8'd0);
        chk("rst.valid_out", valid_out, 8'd0);
        chk("rst.overrun",   overrun,   8'd0);
        chk("rst.isi_out",   isi_out,   8'd0);
        chk("rst.isi_upd",   isi_upd,   8'd0);
        model_reset();
        repeat (2) begin
            spike_in = ~spike_in;
            @(posedge clk);
            #1;
            chk("rst_hold.valid_out", valid_out, 8'd0);
            chk("rst_hold.rate_out",  rate_out,  8'd0);
        end
        spike_in = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; spike_in = 1'b0; en = 1'b0; win_len = 8'd10; ready_in = 1'b1;
        m_cycle = 0;
        model_reset();
        #2;
        do_reset();

        // A: win_len=10, 4 events per window, consumer always ready
        win_len = 8'd10; ready_in = 1'b1; en = 1'b1;
        cyc(1'b0);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 10; k++) begin
                if (w == 0) cyc(k % 3 == 0);
                else        cyc(k == 1 || k == 3 || k == 5 || k == 7);
            end
            chk("A.rate_out", rate_out, 8'd4);
            chk("A.valid_hi", valid_out, 8'd1);
        end
        cyc(1'b0);
        chk("A.valid_one_cycle", valid_out, 8'd0);

        // F: reset mid-window with spikes active, then a full fresh window
        for (int k = 1; k < 6; k++) cyc(k % 2 == 0);
        do_reset();
        cyc(1'b0);
        chk("F.no_valid_entry", valid_out, 8'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(k % 2 == 0);
            if (k < 9) chk("F.no_valid_early", valid_out, 8'd0);
        end
        chk("F.valid_after_window", valid_out, 8'd1);
        chk("F.rate_out", rate_out, 8'd5);

        // B: 256-cycle window, held level then alternating pattern
        do_reset();
        win_len = 8'd0; en = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 256; k++) cyc(k < 20);
        chk("B.held_rate", rate_out, 8'd1);
        for (int k = 0; k < 256; k++) cyc(k % 2 == 0);
        chk("B.alt_rate", rate_out, 8'd128);
        chk("B.alt_valid", valid_out, 8'd1);

        // C: unconsumed result overwritten -> overrun
        do_reset();
        win_len = 8'd10; ready_in = 1'b0; en = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 10; k++) cyc(k == 0 || k == 2);
        chk("C.first_rate", rate_out, 8'd2);
        chk("C.first_overrun", overrun, 8'd0);
        for (int k = 0; k < 10; k++) cyc(k % 2 == 0);
        chk("C.rate_out", rate_out, 8'd5);
        chk("C.valid_out", valid_out, 8'd1);
        chk("C.overrun", overrun, 8'd1);
        en = 1'b0; ready_in = 1'b1;
        cyc(1'b0);
        chk("C.valid_cleared", valid_out, 8'd0);
        chk("C.overrun_sticky", overrun, 8'd1);
        ready_in = 1'b0;
        cyc(1'b0);
        chk("C.overrun_still", overrun, 8'd1);

        // D: inter-spike interval, including saturation
        do_reset();
        win_len = 8'd0; ready_in = 1'b1; en = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 320; k++) begin
            cyc(k == 5 || k == 12 || k == 312);
            if (k == 5)  chk("D.first_no_upd", isi_upd, 8'd0);
            if (k == 12) begin
                chk("D.isi_7", isi_out, 8'd7);
                chk("D.upd_7", isi_upd, 8'd1);
            end
            if (k == 13) chk("D.upd_pulse_end", isi_upd, 8'd0);
            if (k == 312) begin
                chk("D.isi_sat", isi_out, 8'd255);
                chk("D.upd_sat", isi_upd, 8'd1);
            end
        end

        // E: enable dropped mid-window discards the partial count
        do_reset();
        win_len = 8'd10; ready_in = 1'b1; en = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 6; k++) cyc(k == 0 || k == 2 || k == 4);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0);
            chk("E.no_valid_idle", valid_out, 8'd0);
        end
        en = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(k == 1 || k == 5);
            if (k < 9) chk("E.no_valid_early", valid_out, 8'd0);
        end
        chk("E.fresh_rate", rate_out, 8'd2);
        chk("E.fresh_valid", valid_out, 8'd1);

        // Random traffic: spikes, handshakes, enable and window-length changes
        do_reset();
        en = 1'b1; win_len = 8'd7;
        for (int i = 0; i < 3000; i++) begin
            spike_in = ($urandom_range(0, 99) < 40);
            ready_in = ($urandom_range(0, 3) != 0);
            if (en && $urandom_range(0, 299) == 0)       en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0)   en = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 6))
                    0: win_len = 8'd0;
                    1: win_len = 8'd1;
                    2: win_len = 8'd2;
                    3: win_len = 8'd5;
                    4: win_len = 8'd17;
                    5: win_len = 8'd255;
                    default: win_len = 8'($urandom_range(0, 255));
                endcase
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other state SHALL be synchronous to clk.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- spike_in  input  1  spike train, synchronous to clk; one event per 0->1 transition.
- en  input  1  decoding enable, level.
- win_len  input  8  window length in cycles; 0 means 256.
- rate_out  output  8  spike count of the last completed window.
- valid_out  output  1  rate_out holds an unconsumed result.
- ready_in  input  1  consumer accepts rate_out when valid_out and ready_in are both high.
- overrun  output  1  sticky flag: an unconsumed result was overwritten.
- isi_out  output  8  cycles between the last two spike events, saturating at 255.
- isi_upd  output  1  one-cycle pulse when isi_out is updated.
REQ-003 The block SHALL have no parameters; all widths SHALL be fixed as listed above.

Function
REQ-004 The block SHALL register spike_in into spike_prev every cycle, regardless of en.
REQ-005 The block SHALL define a spike event as spike_in=1 and spike_prev=0 in the same cycle; a level held high SHALL count as one event.
REQ-006 The state machine SHALL have two states, IDLE and COUNT.
REQ-007 In IDLE with en=1, the state SHALL go to COUNT on the next cycle with win_cnt=0, spk_cnt=0 and isi_armed=0.
REQ-008 In COUNT with en=0, the state SHALL go to IDLE, the partial window SHALL be discarded, and no result SHALL be produced.
REQ-009 In COUNT, every cycle in which an event occurs SHALL increment spk_cnt.
- spk_cnt is 8 bits.
- Edge detection limits a window to at most 128 events, so spk_cnt cannot overflow.
REQ-010 In COUNT, win_cnt SHALL increment every cycle.
REQ-011 In the cycle where win_cnt equals win_len-1 (255 when win_len=0), the block SHALL:
- load rate_out with spk_cnt plus that cycle's event;
- set valid_out=1;
- clear spk_cnt and win_cnt.
Windows SHALL run back to back with no gap cycles.
REQ-012 win_len SHALL be sampled every cycle; a change mid-window SHALL take effect on the next compare.
REQ-013 If win_cnt already exceeds a new win_len-1, the window SHALL run until win_cnt wraps past 255 and then reaches win_len-1.
REQ-014 While valid_out=1, rate_out SHALL be stable until the handshake or a new result.
REQ-015 valid_out SHALL clear on the cycle after valid_out&ready_in, unless a new result is loaded in that same handshake cycle; in that case valid_out SHALL stay 1 with the new data.
REQ-016 If a new result is loaded while valid_out=1 and ready_in=0, rate_out SHALL be overwritten, valid_out SHALL stay 1, and overrun SHALL be set.
REQ-017 overrun SHALL clear only on reset.
REQ-018 ready_in with valid_out=0 SHALL have no effect.
REQ-019 isi_cnt SHALL be loaded with 1 on an event in COUNT; otherwise it SHALL increment, saturating at 255.
REQ-020 On an event in COUNT with isi_armed=1, the block SHALL load isi_out with isi_cnt and pulse isi_upd for 1 cycle.
REQ-021 Every event in COUNT SHALL set isi_armed=1; the first event after entering COUNT SHALL only arm the measurement.
REQ-022 In IDLE, isi_armed SHALL be 0, and rate_out, isi_out and overrun SHALL hold their values.
REQ-023 In IDLE, a pending valid_out SHALL still complete its handshake.

Reset
REQ-024 When rst_n=0, the block SHALL immediately set the following to 0:
- rate_out, valid_out, overrun, isi_out, isi_upd;
- spike_prev, spk_cnt, win_cnt, isi_cnt, isi_armed.
The state SHALL be IDLE.
REQ-025 Reset mid-window SHALL discard all partial counts.
REQ-026 After rst_n deasserts, the first possible result SHALL complete no earlier than win_len+1 cycles after en=1 is sampled.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset mid-window with spikes active -> all outputs 0 while rst_n=0; no valid_out until a full new window after release.
- win_len=10, ready_in=1, 1-cycle pulses at window cycles 0,3,6,9 -> rate_out=4, valid_out high for exactly 1 cycle, then next windows repeat 4.
- spike_in held high for 20 cycles, win_len=0 -> rate_out=1; alternating 1/0 every cycle, win_len=0 -> rate_out=128.
- ready_in=0 across two windows of 2 then 5 events -> rate_out=5, valid_out=1, overrun=1; a ready_in pulse clears valid_out, and overrun stays 1.
- Events at COUNT cycles 5, 12, then 312 -> isi_out=7 with an isi_upd pulse, then isi_out=255; a first event after en rises gives no isi_upd.
- en dropped at win_cnt=6 of win_len=10 with 3 events -> no valid_out; re-enable gives a fresh full window count.
